// File: rtl/apb2axi_rd_engine.sv
// Single-outstanding AXI read engine: takes one directory read request, issues AR,
// streams R beats straight into the read-data FIFO, then posts one completion entry.
module apb2axi_rd_engine #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXI_ADDR_W-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [1:0]            req_burst,
  input  logic [TAG_W-1:0]      req_tag,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [AXI_ID_W-1:0]   arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [AXI_ID_W-1:0]   rid,
  output logic                  rdf_valid,
  input  logic                  rdf_ready,
  output logic [TAG_W-1:0]      rdf_tag,
  output logic [AXI_DATA_W-1:0] rdf_data,
  output logic                  rdf_last,
  output logic [1:0]            rdf_resp,
  output logic                  cmpl_valid,
  input  logic                  cmpl_ready,
  output logic [TAG_W-1:0]      cmpl_tag,
  output logic [1:0]            cmpl_resp,
  output logic                  cmpl_error,
  output logic [7:0]            cmpl_num_beats
);

  typedef enum logic [1:0] {IDLE, AR, DATA, CMPL} state_t;

  state_t                state, state_nxt;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [TAG_W-1:0]      tag_q;
  logic [AXI_ID_W-1:0]   id_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_acc;
  logic                  err_q;
  logic                  beat_acc;
  logic                  beat_bad;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // AXI resp encodings order by severity, so the numeric max is the worst response.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign id_q     = AXI_ID_W'(tag_q);
  assign beat_acc = (state == DATA) && rvalid && rdf_ready;
  assign beat_bad = (rresp != 2'b00) || (rid != id_q) || (rlast != (beat_cnt == len_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      tag_q    <= '0;
      beat_cnt <= '0;
      resp_acc <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        addr_q   <= req_addr;
        len_q    <= req_len;
        size_q   <= req_size;
        burst_q  <= req_burst;
        tag_q    <= req_tag;
        beat_cnt <= '0;
        resp_acc <= '0;
        err_q    <= 1'b0;
      end
      if (beat_acc) begin
        beat_cnt <= sat_inc8(beat_cnt);
        resp_acc <= resp_max(resp_acc, rresp);
        err_q    <= err_q | beat_bad;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rdf_valid  = 1'b0;
    cmpl_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = DATA;
      end
      // R flows through to the FIFO with no buffering; FIFO backpressure stalls R.
      DATA: begin
        rready    = rdf_ready;
        rdf_valid = rvalid;
        if (beat_acc && rlast) state_nxt = CMPL;
      end
      CMPL: begin
        cmpl_valid = 1'b1;
        if (cmpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign araddr         = addr_q;
  assign arlen          = len_q;
  assign arsize         = size_q;
  assign arburst        = burst_q;
  assign arid           = id_q;
  assign rdf_tag        = tag_q;
  assign rdf_data       = rdata;
  assign rdf_resp       = rresp;
  assign rdf_last       = rlast;
  assign cmpl_tag       = tag_q;
  assign cmpl_resp      = resp_acc;
  assign cmpl_error     = err_q;
  assign cmpl_num_beats = beat_cnt;

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Bench for apb2axi_rd_engine: directed vector table plus randomized transactions
// checked against a beat-list reference model.
module tb_apb2axi_rd_engine;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic [2:0]    req_size;
  logic [1:0]    req_burst;
  logic [TW-1:0] req_tag;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;
  logic          rdf_valid, rdf_ready;
  logic [TW-1:0] rdf_tag;
  logic [DW-1:0] rdf_data;
  logic          rdf_last;
  logic [1:0]    rdf_resp;
  logic          cmpl_valid, cmpl_ready;
  logic [TW-1:0] cmpl_tag;
  logic [1:0]    cmpl_resp;
  logic          cmpl_error;
  logic [7:0]    cmpl_num_beats;

  always #5 clk = ~clk;

  apb2axi_rd_engine #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst), .req_tag(req_tag),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .rdf_valid(rdf_valid), .rdf_ready(rdf_ready), .rdf_tag(rdf_tag), .rdf_data(rdf_data),
    .rdf_last(rdf_last), .rdf_resp(rdf_resp),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag),
    .cmpl_resp(cmpl_resp), .cmpl_error(cmpl_error), .cmpl_num_beats(cmpl_num_beats)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  tag;
    int          ar_delay;
    int          nbeats;
    logic [1:0]  bad_resp;
    int          bad_resp_idx;
    int          bad_rid_idx;
    int          rdf_mode;     // 0 always ready, 1 toggling, 2 random (rvalid gaps too)
    int          cmpl_delay;
    int          rst_after;    // assert reset once this many beats are accepted, -1 never
    logic [1:0]  exp_resp;
    logic        exp_err;
    logic [7:0]  exp_beats;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t base(input logic [63:0] a, input logic [7:0] l, input logic [3:0] t,
                                input int nb, input logic [1:0] er, input logic ee,
                                input logic [7:0] eb);
    vec_t v;
    v.addr = a; v.len = l; v.size = 3'd3; v.burst = 2'd1; v.tag = t;
    v.ar_delay = 0; v.nbeats = nb; v.bad_resp = 2'd0; v.bad_resp_idx = -1;
    v.bad_rid_idx = -1; v.rdf_mode = 0; v.cmpl_delay = 0; v.rst_after = -1;
    v.exp_resp = er; v.exp_err = ee; v.exp_beats = eb;
    return v;
  endfunction

  // Reference: completion is a reduction over the list of beats the slave sends.
  function automatic void model(input vec_t v, output logic [1:0] r, output logic e,
                                output logic [7:0] n);
    r = 2'd0;
    e = 1'b0;
    for (int k = 0; k < v.nbeats; k++) begin
      logic [1:0] rr;
      rr = (k == v.bad_resp_idx) ? v.bad_resp : 2'd0;
      if (rr > r) r = rr;
      if (rr != 2'd0 || k == v.bad_rid_idx || ((k == v.nbeats - 1) != (k == int'(v.len))))
        e = 1'b1;
    end
    n = (v.nbeats > 255) ? 8'd255 : 8'(v.nbeats);
  endfunction

  // Entered mid-cycle while the DUT is idle; returns mid-cycle of the next idle cycle.
  task automatic run_txn(input vec_t v, input logic [1:0] er, input logic ee, input logic [7:0] eb);
    logic [63:0] d;
    int i, cyc;
    bit aborted;
    aborted = 1'b0;
    req_valid = 1'b1; req_addr = v.addr; req_len = v.len; req_size = v.size;
    req_burst = v.burst; req_tag = v.tag;
    arready = 1'b0; rvalid = 1'b0; rdf_ready = 1'b0; cmpl_ready = 1'b0;
    #1;
    chk("req_ready_idle", req_ready, 1);
    chk("arvalid_idle", arvalid, 0);
    @(posedge clk); #2;
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_tag = '0;
    for (int c = 0; c <= v.ar_delay; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      arready = (c == v.ar_delay); rdf_ready = 1'b1; rvalid = 1'b1;
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, v.addr);
      chk("arlen", arlen, v.len);
      chk("arsize", arsize, v.size);
      chk("arburst", arburst, v.burst);
      chk("arid", arid, IW'(v.tag));
      chk("rready_in_ar", rready, 0);
      chk("rdf_valid_in_ar", rdf_valid, 0);
    end
    i = 0; cyc = 0; d = {$urandom, $urandom};
    while (i < v.nbeats && cyc < 2000) begin
      @(posedge clk); #2;
      arready = 1'b0;
      if (v.rst_after >= 0 && i == v.rst_after) begin
        rst = 1'b1; rvalid = 1'b1; rdf_ready = 1'b1; rdata = d; rlast = 1'b0;
        #1;
        chk("rst_rdf_valid", rdf_valid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_cmpl_valid", cmpl_valid, 0);
        repeat (2) begin
          @(posedge clk); #3;
          chk("rst_no_cmpl", cmpl_valid, 0);
          chk("rst_beats_cleared", cmpl_num_beats, 0);
        end
        @(posedge clk); #2;
        rst = 1'b0; rvalid = 1'b0; rdf_ready = 1'b0;
        #1;
        chk("req_ready_after_rst", req_ready, 1);
        chk("cmpl_valid_after_rst", cmpl_valid, 0);
        aborted = 1'b1;
        break;
      end
      case (v.rdf_mode)
        0:       rdf_ready = 1'b1;
        1:       rdf_ready = (cyc % 2 == 0);
        default: rdf_ready = 1'($urandom_range(0, 1));
      endcase
      rvalid = (v.rdf_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata  = d;
      rresp  = (i == v.bad_resp_idx) ? v.bad_resp : 2'd0;
      rid    = (i == v.bad_rid_idx) ? IW'(v.tag ^ 4'h1) : IW'(v.tag);
      rlast  = (i == v.nbeats - 1);
      #1;
      chk("rready", rready, rdf_ready);
      chk("rdf_valid", rdf_valid, rvalid);
      if (rvalid) begin
        chk("rdf_data", rdf_data, d);
        chk("rdf_resp", rdf_resp, rresp);
        chk("rdf_last", rdf_last, rlast);
        chk("rdf_tag", rdf_tag, v.tag);
      end
      if (rvalid && rready) begin
        i++;
        d = {$urandom, $urandom};
      end
      cyc++;
    end
    if (aborted) return;
    chk("beats_accepted", i, v.nbeats);
    for (int c = 0; c <= v.cmpl_delay; c++) begin
      @(posedge clk); #2;
      rvalid = 1'b0; rlast = 1'b0; cmpl_ready = (c == v.cmpl_delay);
      #1;
      chk("cmpl_valid", cmpl_valid, 1);
      chk("cmpl_tag", cmpl_tag, v.tag);
      chk("cmpl_resp", cmpl_resp, er);
      chk("cmpl_error", cmpl_error, ee);
      chk("cmpl_num_beats", cmpl_num_beats, eb);
      chk("req_ready_in_cmpl", req_ready, 0);
      chk("rdf_valid_in_cmpl", rdf_valid, 0);
    end
    @(posedge clk); #2;
    cmpl_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mr;
    logic       me;
    logic [7:0] mb;
    vec_t       v;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    req_tag = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    rid = '0; rdf_ready = 1'b0; cmpl_ready = 1'b0;

    tbl[0]  = base(64'h1000, 8'd0, 4'd3, 1, 2'd0, 1'b0, 8'd1);
    tbl[1]  = base(64'h2000, 8'd3, 4'd5, 4, 2'd0, 1'b0, 8'd4);
    tbl[1].rdf_mode = 1;
    tbl[2]  = base(64'h3000, 8'd3, 4'd1, 4, 2'd2, 1'b1, 8'd4);
    tbl[2].bad_resp = 2'd2; tbl[2].bad_resp_idx = 2;
    tbl[3]  = base(64'h4000, 8'd3, 4'd7, 2, 2'd0, 1'b1, 8'd2);
    tbl[4]  = base(64'h5000, 8'd1, 4'd9, 2, 2'd0, 1'b0, 8'd2);
    tbl[4].ar_delay = 10; tbl[4].cmpl_delay = 3;
    tbl[5]  = base(64'h6000, 8'd2, 4'd2, 3, 2'd0, 1'b1, 8'd3);
    tbl[5].bad_rid_idx = 1;
    tbl[6]  = base(64'h7000, 8'd1, 4'd4, 3, 2'd0, 1'b1, 8'd3);
    tbl[7]  = base(64'h8000, 8'd0, 4'd8, 1, 2'd3, 1'b1, 8'd1);
    tbl[7].bad_resp = 2'd3; tbl[7].bad_resp_idx = 0;
    tbl[8]  = base(64'h9000, 8'd3, 4'd6, 4, 2'd0, 1'b0, 8'd0);
    tbl[8].rst_after = 2;
    tbl[9]  = base(64'hA000, 8'd2, 4'd10, 3, 2'd0, 1'b0, 8'd3);
    tbl[9].ar_delay = 1;
    tbl[10] = base(64'hB000, 8'd255, 4'd15, 256, 2'd0, 1'b0, 8'd255);
    tbl[11] = base(64'hC000, 8'd0, 4'd0, 1, 2'd1, 1'b1, 8'd1);
    tbl[11].bad_resp = 2'd1; tbl[11].bad_resp_idx = 0;

    #12;
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_rdf_valid", rdf_valid, 0);
    chk("reset_cmpl_valid", cmpl_valid, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_arid", arid, 0);
    chk("reset_num_beats", cmpl_num_beats, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 1);
    @(posedge clk); #2;

    for (int t = 0; t < 12; t++)
      run_txn(tbl[t], tbl[t].exp_resp, tbl[t].exp_err, tbl[t].exp_beats);

    for (int t = 0; t < 40; t++) begin
      v = base({$urandom, $urandom}, 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               1, 2'd0, 1'b0, 8'd0);
      v.nbeats = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(v.len) + 3))
                                             : int'(v.len) + 1;
      v.size = 3'($urandom_range(0, 7));
      v.burst = 2'($urandom_range(0, 2));
      v.ar_delay = $urandom_range(0, 3);
      v.cmpl_delay = $urandom_range(0, 3);
      v.rdf_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) begin
        v.bad_resp = 2'($urandom_range(1, 3));
        v.bad_resp_idx = $urandom_range(0, v.nbeats - 1);
      end
      if ($urandom_range(0, 5) == 0) v.bad_rid_idx = $urandom_range(0, v.nbeats - 1);
      model(v, mr, me, mb);
      run_txn(v, mr, me, mb);
    end

    #1;
    chk("final_cmpl_valid", cmpl_valid, 0);
    chk("final_req_ready", req_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb2axi_rd_engine.md
APB2AXI_RD_ENGINE -- requirements
Module: apb2axi_rd_engine

Interface
REQ-001 SHALL have parameters: AXI_ADDR_W, default 64, address width; AXI_DATA_W, default 64, data width; AXI_ID_W, default 4, AXI ID width; TAG_W, default 4, directory tag width (TAG_W <= AXI_ID_W).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
 clk  in  1  single clock, all logic rising-edge
 rst  in  1  reset, asynchronous, active-high
 req_valid  in  1  read request from directory issue path
 req_ready  out  1  request accepted when req_valid && req_ready
 req_addr  in  AXI_ADDR_W  start address
 req_len  in  8  AXI len (beats-1)
 req_size  in  3  AXI size
 req_burst  in  2  AXI burst
 req_tag  in  TAG_W  directory tag
 arvalid/arready  out/in  1/1  AXI AR handshake
 araddr, arlen, arsize, arburst, arid  out  AXI_ADDR_W, 8, 3, 2, AXI_ID_W  AR payload
 rvalid/rready  in/out  1/1  AXI R handshake
 rdata, rresp, rlast, rid  in  AXI_DATA_W, 2, 1, AXI_ID_W  R payload
 rdf_valid/rdf_ready  out/in  1/1  push to read-data FIFO
 rdf_tag, rdf_data, rdf_last, rdf_resp  out  TAG_W, AXI_DATA_W, 1, 2  rdf_entry_t fields
 cmpl_valid/cmpl_ready  out/in  1/1  push to completion queue
 cmpl_tag, cmpl_resp, cmpl_error, cmpl_num_beats  out  TAG_W, 2, 1, 8  completion_entry_t fields (is_write fixed 0)

Function
REQ-003 SHALL implement FSM IDLE -> AR -> DATA -> CMPL -> IDLE; exactly one read outstanding.
REQ-004 IDLE: req_ready=1; on req handshake SHALL register addr/len/size/burst/tag, clear beat counter and accumulators, go AR next cycle.
REQ-005 AR: arvalid=1 with registered payload, arid = tag zero-extended; payload SHALL stay stable until arready; on arvalid && arready go DATA.
REQ-006 DATA: rready = rdf_ready; rdf_valid = rvalid; rdf_data/rdf_resp/rdf_last = rdata/rresp/rlast combinationally; rdf_tag = registered tag; zero added latency.
REQ-007 Beat accepted when rvalid && rready; SHALL increment 8-bit beat counter (saturating at 255).
REQ-008 Accumulated resp SHALL be the numeric max of all accepted rresp values (DECERR/SLVERR dominate OKAY).
REQ-009 Error flag SHALL set if any accepted beat has rresp!=0, rid != arid, or rlast on beat index != len, or no rlast on beat index == len.
REQ-010 Burst SHALL terminate only on accepted beat with rlast=1; go CMPL next cycle.
REQ-011 CMPL: cmpl_valid=1 with cmpl_tag=tag, cmpl_resp=accumulated resp, cmpl_error=error flag, cmpl_num_beats=beats accepted; hold stable until cmpl_ready; on handshake go IDLE.
REQ-012 req_ready, arvalid, rready, rdf_valid, cmpl_valid SHALL be 0 outside the states named above.
REQ-013 Back-to-back: new request accepted the cycle after cmpl handshake (IDLE lasts ≥1 cycle).
REQ-014 rdf_ready low in DATA SHALL stall R (rready=0) with no beat loss or duplication.

Reset
REQ-015 rst assertion SHALL force IDLE asynchronously; all registered payload, counters, flags to 0; all valid outputs 0, req_ready 1 after reset release.
REQ-016 Reset mid-burst SHALL abandon the transaction with no completion emitted.

Verification
REQ-017 Single beat: req addr=0x1000 len=0 tag=3, arready immediate, one R beat rresp=0 rlast=1 -> arid=3, one rdf push last=1, cmpl tag=3 resp=0 error=0 num_beats=1.
REQ-018 4-beat burst, rdf_ready toggling 1/0 each cycle -> 4 rdf pushes in order, no duplicates, num_beats=4.
REQ-019 len=3, beat 2 rresp=2 -> cmpl resp=2 error=1 num_beats=4.
REQ-020 len=3, rlast on beat 1 -> cmpl error=1 num_beats=2, FSM back to IDLE.
REQ-021 arready held low 10 cycles -> AR payload stable all 10 cycles, no rready before handshake.
REQ-022 rst asserted during DATA after 2 beats -> all valids 0 same cycle, no cmpl, next request processed normally.
